// File: rtl/fir_pkg.sv
// Shared state encoding, default widths and output saturation limits for the
// cascaded FIR MAC lanes.
package fir_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_COEF_W = 16;
    localparam int OUT_W      = 16;

    localparam logic [OUT_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [OUT_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } macState_t;

endpackage

// File: rtl/fir_coeff_ram.sv
// Per-lane coefficient register file: synchronous write, asynchronous read by
// the MAC tap index. Writes to addresses at or beyond TAPS match no entry.
module fir_coeff_ram #(
    parameter int TAPS   = 10,
    parameter int COEF_W = 16,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic                     iClk_12M,
    input  logic                     iWrEn,
    input  logic [ADDR_W-1:0]        iWrAddr,
    input  logic signed [COEF_W-1:0] iWrData,
    input  logic [IDX_W-1:0]         iRdIdx,
    output logic signed [COEF_W-1:0] oRdData
);

    logic signed [COEF_W-1:0] coefMem [TAPS];

    always_ff @(posedge iClk_12M) begin
        for (int i = 0; i < TAPS; i++) begin
            if (iWrEn && (iWrAddr == ADDR_W'(i))) begin
                coefMem[i] <= iWrData;
            end
        end
    end

    assign oRdData = coefMem[iRdIdx];

endmodule

// File: rtl/fir_mac_lane.sv
// One serial-MAC lane of the cascaded FIR: delay line, tap FSM, accumulator and
// 16-bit output stage. Define FIR_MAC_SAT_EN to saturate the output instead of wrapping.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = 10,
    parameter int SHIFT  = 3
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iEnSample_600k,
    input  logic signed [DATA_W-1:0] iFirIn,
    input  logic                     iCoeffWr,
    input  logic [3:0]               iCoeffAddr,
    input  logic signed [COEF_W-1:0] iCoeffData,
    output logic signed [DATA_W-1:0] oDelayOut,
    output logic signed [OUT_W-1:0]  oMac,
    output logic                     oMacValid,
    output logic                     oEnDelay,
    output logic                     oOverrun,
    output logic                     oCoeffErr
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(TAPS);
    localparam logic signed [ACC_W-1:0] POS_LIM  = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] NEG_LIM  = ACC_W'(-32'sd32768);

    macState_t stateReg, stateNext;
    logic [IDX_W-1:0]         idxReg, idxNext;
    logic signed [ACC_W-1:0]  accReg, accNext;
    logic [CNT_W-1:0]         fillCntReg, fillCntNext;
    logic signed [DATA_W-1:0] delayReg [TAPS];

    logic                     busy;
    logic                     macLoad;
    logic                     coeffWrEn;
    logic signed [COEF_W-1:0] coefRd;
    logic signed [PROD_W-1:0] sampleExt, coefExt, product;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         macOut;

    assign busy      = (stateReg != IDLE);
    assign coeffWrEn = iCoeffWr && !busy;

    fir_coeff_ram #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W),
        .ADDR_W (4)
    ) uCoeffRam (
        .iClk_12M (iClk_12M),
        .iWrEn    (coeffWrEn),
        .iWrAddr  (iCoeffAddr),
        .iWrData  (iCoeffData),
        .iRdIdx   (idxReg),
        .oRdData  (coefRd)
    );

    // Both operands widened first so the product is exact in PROD_W bits.
    assign sampleExt = PROD_W'(delayReg[idxReg]);
    assign coefExt   = PROD_W'(coefRd);
    assign product   = sampleExt * coefExt;

    assign shifted   = accReg >>> SHIFT;
    assign oDelayOut = delayReg[TAPS-1];

    always_comb begin
        macOut = OUT_W'(shifted);
`ifdef FIR_MAC_SAT_EN
        if (shifted > POS_LIM) begin
            macOut = SAT_POS;
        end else if (shifted < NEG_LIM) begin
            macOut = SAT_NEG;
        end
`endif
    end

    // A strobe always (re)starts the sum, which is how an overrun aborts a busy MAC.
    always_comb begin
        stateNext = stateReg;
        idxNext   = idxReg;
        accNext   = accReg;
        macLoad   = 1'b0;
        if (iEnSample_600k) begin
            stateNext = MAC;
            idxNext   = '0;
            accNext   = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateNext = IDLE;
                end
                MAC: begin
                    accNext = accReg + ACC_W'(product);
                    if (idxReg == LAST_IDX) begin
                        stateNext = OUT;
                    end else begin
                        idxNext = idxReg + 1'b1;
                    end
                end
                OUT: begin
                    stateNext = IDLE;
                    macLoad   = 1'b1;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fillCntNext = fillCntReg;
        if (iEnSample_600k && (fillCntReg != FULL_CNT)) begin
            fillCntNext = fillCntReg + 1'b1;
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            stateReg   <= IDLE;
            idxReg     <= '0;
            accReg     <= '0;
            fillCntReg <= '0;
            oMac       <= '0;
            oMacValid  <= 1'b0;
            oEnDelay   <= 1'b0;
            oOverrun   <= 1'b0;
            oCoeffErr  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                delayReg[k] <= '0;
            end
        end else begin
            stateReg   <= stateNext;
            idxReg     <= idxNext;
            accReg     <= accNext;
            fillCntReg <= fillCntNext;
            oEnDelay   <= (fillCntNext == FULL_CNT);
            oOverrun   <= iEnSample_600k && busy;
            oCoeffErr  <= iCoeffWr && busy;
            oMacValid  <= macLoad;
            if (macLoad) begin
                oMac <= macOut;
            end
            if (iEnSample_600k) begin
                delayReg[0] <= iFirIn;
                for (int k = 1; k < TAPS; k++) begin
                    delayReg[k] <= delayReg[k-1];
                end
            end
        end
    end

endmodule
